// File: rtl/vid_pattern_gen.sv
// Raster test-pattern source: generates vsync/hsync/vde and 8-bit pixel data on pclk.
// Stands in for the camera sensor so the linebuffer/DMA path can run without optics.
module vid_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b1,
    parameter int unsigned CHECK_LOG2 = 3
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        vsync,
    output logic        hsync,
    output logic        vde,
    output logic [7:0]  o_data,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAR_W    = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        r_state, w_state_next;
    logic [HW-1:0] r_h, w_h_next;
    logic [VW-1:0] r_v, w_v_next;
    logic [15:0]   r_frame_count, w_frame_count_next;
    logic [1:0]    r_sel, w_sel_next;
    logic          r_vde, w_vde_next;
    logic          r_hsync, w_hsync_next;
    logic          r_vsync, w_vsync_next;
    logic [7:0]    r_data, w_data_next;

    logic [31:0]   w_h32, w_v32, w_bar32;
    logic [2:0]    w_bar;
    logic [7:0]    w_pix;
    logic          w_h_last, w_v_last, w_run;

    assign w_h32    = 32'(r_h);
    assign w_v32    = 32'(r_v);
    assign w_h_last = (w_h32 == H_TOTAL - 1);
    assign w_v_last = (w_v32 == V_TOTAL - 1);
    assign w_run    = (r_state == StRun);

    // Counter/FSM next state; pattern_sel is captured only when a frame starts at (0,0).
    always_comb begin
        w_state_next       = r_state;
        w_h_next           = r_h;
        w_v_next           = r_v;
        w_frame_count_next = r_frame_count;
        w_sel_next         = r_sel;
        unique case (r_state)
            StIdle: begin
                w_h_next = '0;
                w_v_next = '0;
                if (enable) begin
                    w_state_next = StRun;
                    w_sel_next   = pattern_sel;
                end
            end
            StRun: begin
                if (w_h_last) begin
                    w_h_next = '0;
                    if (w_v_last) begin
                        w_v_next           = '0;
                        w_frame_count_next = r_frame_count + 16'd1;
                        if (enable) begin
                            w_sel_next = pattern_sel;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end else begin
                        w_v_next = r_v + VW'(1);
                    end
                end else begin
                    w_h_next = r_h + HW'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Frame fill uses the live count: it only changes on the frame's last (blanked) cycle.
    always_comb begin
        w_bar32 = w_h32 / BAR_W;
        w_bar   = (w_bar32 > 32'd7) ? 3'd7 : w_bar32[2:0];
        w_pix   = 8'h00;
        unique case (r_sel)
            2'd0:    w_pix = 8'hFF - {w_bar, 5'b0_0000};
            2'd1:    w_pix = w_h32[7:0];
            2'd2:    w_pix = (w_h32[CHECK_LOG2] ^ w_v32[CHECK_LOG2]) ? 8'hFF : 8'h00;
            default: w_pix = r_frame_count[7:0];
        endcase
    end

    always_comb begin
        w_vde_next   = w_run && (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
        w_hsync_next = (w_run && (w_h32 >= HS_START) && (w_h32 < HS_END)) ? HSYNC_POL
                                                                            : ~HSYNC_POL;
        w_vsync_next = (w_run && (w_v32 >= VS_START) && (w_v32 < VS_END)) ? VSYNC_POL
                                                                            : ~VSYNC_POL;
        w_data_next  = w_vde_next ? w_pix : 8'h00;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_h           <= '0;
            r_v           <= '0;
            r_frame_count <= 16'd0;
            r_sel         <= 2'd0;
            r_vde         <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_data        <= 8'h00;
        end else begin
            r_state       <= w_state_next;
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_frame_count <= w_frame_count_next;
            r_sel         <= w_sel_next;
            r_vde         <= w_vde_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_data        <= w_data_next;
        end
    end

    assign vsync       = r_vsync;
    assign hsync       = r_hsync;
    assign vde         = r_vde;
    assign o_data      = r_data;
    assign frame_count = r_frame_count;

endmodule
